rv32i_coz_asama: RTL and testbench

RV32I_COZ_ASAMA -- requirements
Module: rv32i_coz_asama

---
 rtl/rv32i_coz_asama_pkg.sv | 66 ++++++
 rtl/rv32i_coz_comb.sv | 157 +++++++++++++++
 rtl/rv32i_coz_asama.sv | 146 ++++++++++++++
 tb/tb_rv32i_coz_asama.sv | 561 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_coz_asama_pkg.sv
// Shared decode constants and bundle types for the
// rv32i decode stage.
package rv32i_paket;

  localparam int XLEN = 32;
  localparam int OP_W = 5;
  localparam int RD_W = 5;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [OP_W-1:0] AOP_SUB   = 5'b01010;
  localparam logic [OP_W-1:0] AOP_LUI   = 5'b11100;
  localparam logic [OP_W-1:0] AOP_AUIPC = 5'b11101;
  localparam logic [OP_W-1:0] AOP_JAL   = 5'b11110;
  localparam logic [OP_W-1:0] AOP_JALR  = 5'b11111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // SRC_SHREG: imm2 carries funct7[5] at bit 5, low
  // five bits come from the rs2 value
  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_REG,
    SRC_IMM,
    SRC_SHREG
  } src_t;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [RD_W-1:0] rd;
    logic            illegal;
    logic            use1;
    logic            use2;
    src_t            s1;
    src_t            s2;
    logic [XLEN-1:0] imm1;
    logic [XLEN-1:0] imm2;
    logic [XLEN-1:0] imm3;
  } dec_t;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic [XLEN-1:0] in3;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } bundle_t;

  function automatic logic [XLEN-1:0] sext12(
    input logic [11:0] v
  );
    return {{(XLEN-12){v[11]}}, v};
  endfunction

endpackage

// File: rtl/rv32i_coz_comb.sv
// Pure instruction decode: class, a_op code, immediates,
// operand sources, illegality and source-use flags.
module rv32i_coz_comb
  import rv32i_paket::*;
#(
  parameter int REG_COUNT = 32
) (
  input  logic [XLEN-1:0] instr,
  output dec_t            dec
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] s_imm;
  logic [XLEN-1:0] b_imm;
  logic [XLEN-1:0] u_imm;
  logic [XLEN-1:0] j_imm;
  logic [XLEN-1:0] sh_imm;
  logic f7_zero;
  logic f7_alt;
  logic wr;
  logic bad;
  dec_t d;

  assign opc = instr[6:0];
  assign rd  = instr[11:7];
  assign f3  = instr[14:12];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign f7  = instr[31:25];

  assign i_imm  = sext12(instr[31:20]);
  assign s_imm  = sext12({instr[31:25], instr[11:7]});
  assign b_imm  = {{19{instr[31]}}, instr[31], instr[7],
                   instr[30:25], instr[11:8], 1'b0};
  assign u_imm  = {instr[31:12], 12'b0};
  assign j_imm  = {{11{instr[31]}}, instr[31],
                   instr[19:12], instr[20],
                   instr[30:21], 1'b0};
  assign sh_imm = {26'b0, f7[5], rs2};

  assign f7_zero = (f7 == F7_ZERO);
  assign f7_alt  = (f7 == F7_ALT);

  function automatic logic reg_ok(input logic [4:0] r);
    return int'(r) < REG_COUNT;
  endfunction

  always_comb begin
    d   = '0;
    wr  = 1'b0;
    bad = 1'b0;
    unique case (opc)
      OPC_OPIMM: begin
        d.op   = {2'b00, f3};
        d.use1 = 1'b1;
        d.s1   = SRC_REG;
        d.s2   = SRC_IMM;
        d.imm2 = i_imm;
        wr     = 1'b1;
        if (f3 == 3'b001) begin
          d.imm2 = sh_imm;
          bad    = !f7_zero;
        end else if (f3 == 3'b101) begin
          d.imm2 = sh_imm;
          bad    = !(f7_zero || f7_alt);
        end
      end
      OPC_OP: begin
        d.op   = (f3 == 3'b000 && f7_alt) ?
                 AOP_SUB : {2'b00, f3};
        d.use1 = 1'b1;
        d.use2 = 1'b1;
        d.s1   = SRC_REG;
        d.s2   = SRC_REG;
        wr     = 1'b1;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          d.s2   = SRC_SHREG;
          d.imm2 = {26'b0, f7[5], 5'b0};
        end
        if (f3 == 3'b000 || f3 == 3'b101)
          bad = !(f7_zero || f7_alt);
        else
          bad = !f7_zero;
      end
      OPC_BRANCH: begin
        d.op   = {2'b01, f3};
        d.use1 = 1'b1;
        d.use2 = 1'b1;
        d.s1   = SRC_REG;
        d.s2   = SRC_REG;
        d.imm3 = b_imm;
        bad    = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LOAD: begin
        d.op   = {2'b10, f3};
        d.use1 = 1'b1;
        d.s1   = SRC_REG;
        d.s2   = SRC_IMM;
        d.imm2 = i_imm;
        wr     = 1'b1;
        bad    = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        d.op   = {2'b11, f3};
        d.use1 = 1'b1;
        d.use2 = 1'b1;
        d.s1   = SRC_REG;
        d.s2   = SRC_REG;
        d.imm3 = s_imm;
        bad    = (f3 >= 3'b011);
      end
      OPC_LUI, OPC_AUIPC: begin
        d.op   = (opc == OPC_LUI) ? AOP_LUI : AOP_AUIPC;
        d.s1   = SRC_IMM;
        d.imm1 = u_imm;
        wr     = 1'b1;
      end
      OPC_JAL: begin
        d.op   = AOP_JAL;
        d.s1   = SRC_IMM;
        d.imm1 = j_imm;
        wr     = 1'b1;
      end
      OPC_JALR: begin
        d.op   = AOP_JALR;
        d.use1 = 1'b1;
        d.s1   = SRC_REG;
        d.s2   = SRC_IMM;
        d.imm2 = i_imm;
        wr     = 1'b1;
      end
      default: bad = 1'b1;
    endcase

    // RV32E: only referenced fields are range-checked
    if (wr && !reg_ok(rd))       bad = 1'b1;
    if (d.use1 && !reg_ok(rs1))  bad = 1'b1;
    if (d.use2 && !reg_ok(rs2))  bad = 1'b1;

    d.rd = wr ? rd : '0;

    if (bad) begin
      d         = '0;
      d.illegal = 1'b1;
      d.s1      = SRC_IMM;
      d.imm1    = instr;
    end
    dec = d;
  end

endmodule

// File: rtl/rv32i_coz_asama.sv
// Decode stage: fetch/execute handshake, busy-bit
// scoreboard and writeback bypass around rv32i_coz_comb.
module rv32i_coz_asama
  import rv32i_paket::*;
#(
  parameter int REG_COUNT = 32,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rf_rs1_addr,
  output logic [4:0]      rf_rs2_addr,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] a_op,
  output logic [RD_W-1:0] a_rd,
  output logic [XLEN-1:0] a_in1,
  output logic [XLEN-1:0] a_in2,
  output logic [XLEN-1:0] a_in3,
  output logic [XLEN-1:0] a_pc,
  output logic            a_illegal
);

  dec_t    dec;
  bundle_t held;
  bundle_t nxt;

  logic [REG_COUNT-1:0] busy;
  logic [REG_COUNT-1:0] busy_nxt;
  logic [31:0]          busy_w;

  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic fwd1;
  logic fwd2;
  logic hz1;
  logic hz2;
  logic stall;
  logic cap;

  rv32i_coz_comb #(
    .REG_COUNT(REG_COUNT)
  ) u_comb (
    .instr(in_instr),
    .dec  (dec)
  );

  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];
  assign rf_rs1_addr = rs1;
  assign rf_rs2_addr = rs2;

  assign busy_w = 32'(busy);

  assign fwd1 = WB_BYPASS && wb_valid &&
                (wb_rd == rs1) && (rs1 != 5'd0);
  assign fwd2 = WB_BYPASS && wb_valid &&
                (wb_rd == rs2) && (rs2 != 5'd0);

  assign rs1_val = (rs1 == 5'd0) ? '0 :
                   fwd1 ? wb_data : rf_rs1_data;
  assign rs2_val = (rs2 == 5'd0) ? '0 :
                   fwd2 ? wb_data : rf_rs2_data;

  assign hz1 = dec.use1 && (rs1 != 5'd0) &&
               busy_w[rs1] && !fwd1;
  assign hz2 = dec.use2 && (rs2 != 5'd0) &&
               busy_w[rs2] && !fwd2;
  assign stall = hz1 || hz2;

  assign in_ready = !stall && (!out_valid || out_ready);
  assign cap = in_valid && in_ready && !flush;

  always_comb begin
    nxt         = '0;
    nxt.op      = dec.op;
    nxt.rd      = dec.rd;
    nxt.illegal = dec.illegal;
    nxt.pc      = in_pc;
    nxt.in3     = dec.imm3;
    unique case (dec.s1)
      SRC_REG: nxt.in1 = rs1_val;
      SRC_IMM: nxt.in1 = dec.imm1;
      default: nxt.in1 = '0;
    endcase
    unique case (dec.s2)
      SRC_REG:   nxt.in2 = rs2_val;
      SRC_IMM:   nxt.in2 = dec.imm2;
      SRC_SHREG: nxt.in2 = dec.imm2 |
                           {27'b0, rs2_val[4:0]};
      default:   nxt.in2 = '0;
    endcase
  end

  // clear first so a same-cycle set on one register wins
  always_comb begin
    busy_nxt = busy;
    for (int i = 1; i < REG_COUNT; i++) begin
      if (wb_valid && int'(wb_rd) == i)
        busy_nxt[i] = 1'b0;
      if (cap && !dec.illegal && int'(dec.rd) == i)
        busy_nxt[i] = 1'b1;
    end
    if (flush)
      busy_nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      held      <= '0;
      busy      <= '0;
    end else begin
      busy <= busy_nxt;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (cap) begin
        out_valid <= 1'b1;
        held      <= nxt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign a_op      = held.op;
  assign a_rd      = held.rd;
  assign a_in1     = held.in1;
  assign a_in2     = held.in2;
  assign a_in3     = held.in3;
  assign a_pc      = held.pc;
  assign a_illegal = held.illegal;

endmodule

// File: tb/tb_rv32i_coz_asama.sv
// Randomized and directed bench for rv32i_coz_asama
// against a behavioural decode/scoreboard model.
module tb_rv32i_coz_asama;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rf_rs1_addr;
  logic [4:0]  rf_rs2_addr;
  logic [31:0] rf_rs1_data;
  logic [31:0] rf_rs2_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  a_op;
  logic [4:0]  a_rd;
  logic [31:0] a_in1;
  logic [31:0] a_in2;
  logic [31:0] a_in3;
  logic [31:0] a_pc;
  logic        a_illegal;

  logic        in_ready_e;
  logic [4:0]  rf_rs1_addr_e;
  logic [4:0]  rf_rs2_addr_e;
  logic        out_valid_e;
  logic [4:0]  a_op_e;
  logic [4:0]  a_rd_e;
  logic [31:0] a_in1_e;
  logic [31:0] a_in2_e;
  logic [31:0] a_in3_e;
  logic [31:0] a_pc_e;
  logic        a_illegal_e;

  int n_checks = 0;
  int n_fail = 0;

  bit          m_valid;
  logic [4:0]  m_op;
  logic [4:0]  m_rd;
  logic [31:0] m_in1;
  logic [31:0] m_in2;
  logic [31:0] m_in3;
  logic [31:0] m_pc;
  bit          m_ill;
  bit          m_busy [32];
  bit          seen_ready;

  always #5 clk = ~clk;

  rv32i_coz_asama dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .rf_rs1_addr(rf_rs1_addr),
    .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data),
    .rf_rs2_data(rf_rs2_data),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .a_op       (a_op),
    .a_rd       (a_rd),
    .a_in1      (a_in1),
    .a_in2      (a_in2),
    .a_in3      (a_in3),
    .a_pc       (a_pc),
    .a_illegal  (a_illegal)
  );

  rv32i_coz_asama #(
    .REG_COUNT(16)
  ) dut_e (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready_e),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .rf_rs1_addr(rf_rs1_addr_e),
    .rf_rs2_addr(rf_rs2_addr_e),
    .rf_rs1_data(rf_rs1_data),
    .rf_rs2_data(rf_rs2_data),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .flush      (flush),
    .out_valid  (out_valid_e),
    .out_ready  (out_ready),
    .a_op       (a_op_e),
    .a_rd       (a_rd_e),
    .a_in1      (a_in1_e),
    .a_in2      (a_in2_e),
    .a_in3      (a_in3_e),
    .a_pc       (a_pc_e),
    .a_illegal  (a_illegal_e)
  );

  // Reference decode written straight from the ISA rules
  function automatic void mdec(
    input  logic [31:0] w,
    input  int          rc,
    input  logic [31:0] r1,
    input  logic [31:0] r2,
    output logic [4:0]  op,
    output logic [4:0]  rd,
    output logic [31:0] i1,
    output logic [31:0] i2,
    output logic [31:0] i3,
    output bit          ill,
    output bit          u1,
    output bit          u2
  );
    int f3 = int'(w[14:12]);
    int f7 = int'(w[31:25]);
    int d  = int'(w[11:7]);
    int s1 = int'(w[19:15]);
    int s2 = int'(w[24:20]);
    int sh = int'(w[24:20]);
    logic [31:0] iimm = {{20{w[31]}}, w[31:20]};
    logic [31:0] simm = {{20{w[31]}}, w[31:25], w[11:7]};
    logic [31:0] bimm = {{19{w[31]}}, w[31], w[7],
                         w[30:25], w[11:8], 1'b0};
    logic [31:0] jimm = {{11{w[31]}}, w[31], w[19:12],
                         w[20], w[30:21], 1'b0};
    logic [31:0] uimm = w & 32'hFFFF_F000;
    bit ok = 1;
    bit wr = 0;
    op = 0; i1 = 0; i2 = 0; i3 = 0; u1 = 0; u2 = 0;
    case (w[6:0])
      7'h13: begin
        op = 5'(f3); wr = 1; u1 = 1; i1 = r1;
        if (f3 == 1) begin
          ok = (f7 == 0); i2 = 32'(sh);
        end else if (f3 == 5) begin
          ok = (f7 == 0 || f7 == 32);
          i2 = 32'((f7 == 32 ? 32 : 0) + sh);
        end else i2 = iimm;
      end
      7'h33: begin
        wr = 1; u1 = 1; u2 = 1; i1 = r1;
        op = (f3 == 0 && f7 == 32) ? 5'd10 : 5'(f3);
        if (f3 == 1 || f3 == 5)
          i2 = 32'((f7 == 32 ? 32 : 0) + int'(r2 % 32));
        else i2 = r2;
        if (f3 == 0 || f3 == 5) ok = (f7 == 0 || f7 == 32);
        else ok = (f7 == 0);
      end
      7'h63: begin
        op = 5'(8 + f3); u1 = 1; u2 = 1;
        i1 = r1; i2 = r2; i3 = bimm;
        ok = (f3 != 2 && f3 != 3);
      end
      7'h03: begin
        op = 5'(16 + f3); u1 = 1; wr = 1;
        i1 = r1; i2 = iimm;
        ok = !(f3 == 3 || f3 == 6 || f3 == 7);
      end
      7'h23: begin
        op = 5'(24 + f3); u1 = 1; u2 = 1;
        i1 = r1; i2 = r2; i3 = simm; ok = (f3 < 3);
      end
      7'h37: begin op = 28; wr = 1; i1 = uimm; end
      7'h17: begin op = 29; wr = 1; i1 = uimm; end
      7'h6f: begin op = 30; wr = 1; i1 = jimm; end
      7'h67: begin
        op = 31; wr = 1; u1 = 1; i1 = r1; i2 = iimm;
      end
      default: ok = 0;
    endcase
    if ((wr && d >= rc) || (u1 && s1 >= rc) ||
        (u2 && s2 >= rc))
      ok = 0;
    rd = wr ? 5'(d) : 5'd0;
    ill = !ok;
    if (ill) begin
      op = 0; rd = 0; i1 = w; i2 = 0; i3 = 0;
      u1 = 0; u2 = 0;
    end
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 15);
    logic [6:0] opc;
    case (k)
      0, 1:    opc = 7'h33;
      2:       opc = 7'h63;
      3, 4:    opc = 7'h03;
      5:       opc = 7'h23;
      6:       opc = 7'h37;
      7:       opc = 7'h17;
      8:       opc = 7'h6f;
      9:       opc = 7'h67;
      10:      opc = w[6:0];
      default: opc = 7'h13;
    endcase
    w[6:0] = opc;
    if (k != 10) begin
      w[11:7]  = 5'($urandom_range(0, 7));
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 7) != 0)
        w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    end
    return w;
  endfunction

  task automatic clear_in();
    in_valid = 0; in_instr = 0; in_pc = 0;
    rf_rs1_data = 0; rf_rs2_data = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic model_reset();
    m_valid = 0; m_op = 0; m_rd = 0; m_in1 = 0;
    m_in2 = 0; m_in3 = 0; m_pc = 0; m_ill = 0;
    foreach (m_busy[i]) m_busy[i] = 0;
  endtask

  // One clock: inputs already driven at the negedge
  task automatic run_cycle();
    logic [31:0] r1, r2, i1, i2, i3;
    logic [4:0] op, rd;
    bit ill, u1, u2, st, rdy, cap;
    int s1, s2;
    #1;
    s1 = int'(in_instr[19:15]);
    s2 = int'(in_instr[24:20]);
    r1 = (s1 == 0) ? 0 : (wb_valid && int'(wb_rd) == s1)
         ? wb_data : rf_rs1_data;
    r2 = (s2 == 0) ? 0 : (wb_valid && int'(wb_rd) == s2)
         ? wb_data : rf_rs2_data;
    mdec(in_instr, 32, r1, r2, op, rd, i1, i2, i3,
         ill, u1, u2);
    st = (u1 && s1 != 0 && m_busy[s1] &&
          !(wb_valid && int'(wb_rd) == s1)) ||
         (u2 && s2 != 0 && m_busy[s2] &&
          !(wb_valid && int'(wb_rd) == s2));
    rdy = !st && (!m_valid || out_ready);
    seen_ready = in_ready;
    n_checks++;
    if (in_ready !== rdy) begin
      n_fail++;
      $display("FAIL in_ready: got %b want %b instr %h",
               in_ready, rdy, in_instr);
    end
    cap = in_valid && rdy && !flush;
    if (flush) begin
      m_valid = 0;
      foreach (m_busy[i]) m_busy[i] = 0;
    end else begin
      if (wb_valid) m_busy[wb_rd] = 0;
      if (cap) begin
        m_valid = 1; m_op = op; m_rd = rd; m_in1 = i1;
        m_in2 = i2; m_in3 = i3; m_pc = in_pc; m_ill = ill;
        if (!ill && rd != 0) m_busy[rd] = 1;
      end else if (out_ready) m_valid = 0;
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== m_valid) begin
      n_fail++;
      $display("FAIL out_valid: got %b want %b",
               out_valid, m_valid);
    end
    if (m_valid) begin
      n_checks++;
      if ({a_op, a_rd, a_in1, a_in2, a_in3, a_pc,
           a_illegal} !== {m_op, m_rd, m_in1, m_in2,
           m_in3, m_pc, m_ill}) begin
        n_fail++;
        $display("FAIL bundle: got op=%h rd=%0d in1=%h in2=%h in3=%h pc=%h ill=%b want op=%h rd=%0d in1=%h in2=%h in3=%h pc=%h ill=%b",
                 a_op, a_rd, a_in1, a_in2, a_in3, a_pc,
                 a_illegal, m_op, m_rd, m_in1, m_in2,
                 m_in3, m_pc, m_ill);
      end
    end
    @(negedge clk);
  endtask

  task automatic flush_cycle();
    clear_in();
    flush = 1;
    run_cycle();
    flush = 0;
  endtask

  task automatic test_reset();
    clear_in();
    rst = 1;
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    n_checks++;
    if ({a_op, a_rd, a_in1, a_in2, a_in3, a_pc,
         a_illegal} !== '0) begin
      n_fail++;
      $display("FAIL reset_bundle: got op=%h in1=%h pc=%h want 0",
               a_op, a_in1, a_pc);
    end
    rst = 0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_addi();
    flush_cycle();
    in_valid = 1;
    in_instr = 32'hFFF0_8293;
    in_pc = 32'h0000_0040;
    rf_rs1_data = 32'd10;
    run_cycle();
    n_checks++;
    if ({out_valid, a_op, a_in1, a_in2, a_rd} !==
        {1'b1, 5'b00000, 32'd10, 32'hFFFF_FFFF, 5'd5}) begin
      n_fail++;
      $display("FAIL addi: got v=%b op=%h in1=%h in2=%h rd=%0d want v=1 op=0 in1=a in2=ffffffff rd=5",
               out_valid, a_op, a_in1, a_in2, a_rd);
    end
  endtask

  task automatic test_load_use();
    flush_cycle();
    in_valid = 1;
    in_instr = 32'h0000_A183;
    rf_rs1_data = 32'd100;
    run_cycle();
    in_instr = 32'h0021_8233;
    rf_rs2_data = 32'd7;
    for (int i = 0; i < 2; i++) begin
      run_cycle();
      n_checks++;
      if (seen_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL load_use_stall: in_ready got %b want 0",
                 seen_ready);
      end
    end
    wb_valid = 1;
    wb_rd = 5'd3;
    wb_data = 32'h1234_5678;
    run_cycle();
    n_checks++;
    if ({seen_ready, a_in1, a_in2, a_rd} !==
        {1'b1, 32'h1234_5678, 32'd7, 5'd4}) begin
      n_fail++;
      $display("FAIL load_use_bypass: got rdy=%b in1=%h in2=%h rd=%0d want rdy=1 in1=12345678 in2=7 rd=4",
               seen_ready, a_in1, a_in2, a_rd);
    end
    wb_valid = 0;
  endtask

  task automatic test_sub_srai();
    flush_cycle();
    in_valid = 1;
    in_instr = 32'h4031_00B3;
    rf_rs1_data = 32'h50;
    rf_rs2_data = 32'h30;
    run_cycle();
    n_checks++;
    if ({a_op, a_in1, a_in2, a_rd} !==
        {5'b01010, 32'h50, 32'h30, 5'd1}) begin
      n_fail++;
      $display("FAIL sub: got op=%b in1=%h in2=%h rd=%0d want op=01010 in1=50 in2=30 rd=1",
               a_op, a_in1, a_in2, a_rd);
    end
    in_instr = 32'h4071_5093;
    run_cycle();
    n_checks++;
    if ({a_op, a_in2} !== {5'b00101, 32'h27}) begin
      n_fail++;
      $display("FAIL srai: got op=%b in2=%h want op=00101 in2=27",
               a_op, a_in2);
    end
  endtask

  task automatic test_illegal();
    flush_cycle();
    in_valid = 1;
    in_instr = 32'h0000_A183;
    run_cycle();
    in_instr = 32'h0020_C023;
    run_cycle();
    n_checks++;
    if ({a_illegal, a_in1, a_op, a_rd} !==
        {1'b1, 32'h0020_C023, 5'd0, 5'd0}) begin
      n_fail++;
      $display("FAIL store_illegal: got ill=%b in1=%h op=%h rd=%0d want ill=1 in1=0020c023 op=0 rd=0",
               a_illegal, a_in1, a_op, a_rd);
    end
    in_instr = 32'h0021_8233;
    run_cycle();
    n_checks++;
    if (seen_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_keeps_busy: in_ready got %b want 0",
               seen_ready);
    end
    flush_cycle();
    in_valid = 1;
    in_instr = 32'h0010_8A13;
    run_cycle();
    n_checks++;
    if ({a_illegal_e, a_in1_e, out_valid_e, a_illegal} !==
        {1'b1, 32'h0010_8A13, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL rv32e_rd20: got ill_e=%b in1_e=%h v_e=%b ill=%b want 1 00108a13 1 0",
               a_illegal_e, a_in1_e, out_valid_e, a_illegal);
    end
    in_instr = 32'h0010_8293;
    run_cycle();
    n_checks++;
    if ({a_illegal_e, a_rd_e} !== {1'b0, 5'd5}) begin
      n_fail++;
      $display("FAIL rv32e_rd5: got ill_e=%b rd_e=%0d want 0 5",
               a_illegal_e, a_rd_e);
    end
  endtask

  task automatic test_backpressure();
    logic [110:0] hold;
    flush_cycle();
    in_valid = 1;
    in_instr = 32'h0050_0313;
    in_pc = 32'h100;
    run_cycle();
    hold = {a_op, a_rd, a_in1, a_in2, a_pc};
    n_checks++;
    if ({a_in1, a_in2, a_rd} !== {32'd0, 32'd5, 5'd6}) begin
      n_fail++;
      $display("FAIL bp_capture: got in1=%h in2=%h rd=%0d want 0 5 6",
               a_in1, a_in2, a_rd);
    end
    in_instr = 32'h0063_03B3;
    in_pc = 32'h104;
    out_ready = 0;
    run_cycle();
    n_checks++;
    if ({seen_ready, out_valid} !== 2'b01 ||
        {a_op, a_rd, a_in1, a_in2, a_pc} !== hold) begin
      n_fail++;
      $display("FAIL bp_hold: got rdy=%b v=%b pc=%h want rdy=0 v=1 pc=100",
               seen_ready, out_valid, a_pc);
    end
    flush = 1;
    run_cycle();
    n_checks++;
    if ({seen_ready, out_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL bp_flush: got rdy=%b v=%b want 0 0",
               seen_ready, out_valid);
    end
    flush = 0;
    run_cycle();
    n_checks++;
    if ({seen_ready, out_valid, a_pc} !==
        {2'b11, 32'h104}) begin
      n_fail++;
      $display("FAIL bp_after_flush: got rdy=%b v=%b pc=%h want 1 1 104",
               seen_ready, out_valid, a_pc);
    end
    out_ready = 1;
  endtask

  task automatic test_reset_mid();
    flush_cycle();
    in_valid = 1;
    in_instr = 32'hFFF0_8293;
    in_pc = 32'h200;
    rf_rs1_data = 32'd10;
    run_cycle();
    in_valid = 0;
    #2;
    rst = 1;
    #1;
    n_checks++;
    if ({out_valid, a_op, a_rd, a_in1, a_in2, a_in3,
         a_pc, a_illegal} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b in1=%h in2=%h pc=%h want all 0",
               out_valid, a_in1, a_in2, a_pc);
    end
    model_reset();
    @(negedge clk);
    rst = 0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    clear_in();
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_instr = rand_instr();
      in_pc = $urandom;
      rf_rs1_data = $urandom;
      rf_rs2_data = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      wb_valid = ($urandom_range(0, 2) == 0);
      wb_rd = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      flush = ($urandom_range(0, 39) == 0);
      run_cycle();
    end
    clear_in();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    clear_in();
    model_reset();
    @(negedge clk);
    test_reset();
    test_addi();
    test_load_use();
    test_sub_srai();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
